// File: rtl/npc_predict_if.sv
// ---------------------------------------------------------------------------
// npc_predict_if
//   Bundles the IF/ID-side signals of the next-PC predict/resolve unit.
//   master : the pipeline. It drives the fetch and decode information and
//            receives the prediction, the redirect and the mispredict count.
//   slave  : npc_predict_unit.
//   Signals
//     if_valid, if_pc            fetch slot and its word address
//     pred_npc, pred_taken       BTB prediction for the fetch slot
//     id_*                       instruction in ID: valid, stall, pc and
//                                the pred_npc it was fetched with
//     is_branch, branch_avail,   conditional branch and its outcome and
//     offset                     word offset
//     jmp, instr_index           J/JAL and its target field
//     npc_from_gpr, reg_index    JR/JALR and the GPR byte address
//     npc_from_epc, epc          ERET and the EPC word address
//     go_exc                     exception taken
//     redirect, redirect_pc      fetch flush and the PC to refetch from
//     mispredict_cnt             saturating count of non-exception redirects
// ---------------------------------------------------------------------------
interface npc_predict_if #(
    parameter int CNT_W = 32
);
    logic             if_valid;
    logic [29:0]      if_pc;
    logic [29:0]      pred_npc;
    logic             pred_taken;
    logic             id_valid;
    logic             id_stall;
    logic [29:0]      id_pc;
    logic [29:0]      id_pred_npc;
    logic             is_branch;
    logic             branch_avail;
    logic [15:0]      offset;
    logic             jmp;
    logic [25:0]      instr_index;
    logic             npc_from_gpr;
    logic [31:0]      reg_index;
    logic             npc_from_epc;
    logic [29:0]      epc;
    logic             go_exc;
    logic             redirect;
    logic [29:0]      redirect_pc;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output if_valid, if_pc, id_valid, id_stall, id_pc, id_pred_npc,
               is_branch, branch_avail, offset, jmp, instr_index,
               npc_from_gpr, reg_index, npc_from_epc, epc, go_exc,
        input  pred_npc, pred_taken, redirect, redirect_pc, mispredict_cnt
    );

    modport slave (
        input  if_valid, if_pc, id_valid, id_stall, id_pc, id_pred_npc,
               is_branch, branch_avail, offset, jmp, instr_index,
               npc_from_gpr, reg_index, npc_from_epc, epc, go_exc,
        output pred_npc, pred_taken, redirect, redirect_pc, mispredict_cnt
    );
endinterface

// File: rtl/npc_predict_unit.sv
// ---------------------------------------------------------------------------
// npc_predict_unit
//   Next-PC unit at the IF/ID boundary.
//   - IF side: direct-mapped BTB with 2-bit saturating counters predicts the
//     next fetch word address.
//   - ID side: resolves the real next PC with priority
//       exception > ERET > JR > J > taken branch > fall-through
//     and raises a redirect when it differs from what was predicted.
//   - Trains the BTB from resolved control flow and counts mispredicts.
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous, active-high; clears BTB valid bits and the count
//     bus    npc_predict_if.slave (see the interface header)
// ---------------------------------------------------------------------------
module npc_predict_unit #(
    parameter int          ENTRIES     = 16,
    parameter logic [29:0] EXC_HANDLER = 30'h00001060,
    parameter int          CNT_W       = 32
) (
    input  logic          clk,
    input  logic          reset,
    npc_predict_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    // BTB storage. Only the valid bits carry reset; the payload is
    // meaningless until its valid bit is set.
    logic [ENTRIES-1:0] valid_reg;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [29:0]        tgt_mem [ENTRIES];
    logic [1:0]         ctr_mem [ENTRIES];

    logic [CNT_W-1:0]   cnt_reg;

    // ------------------------------------------------------------------
    // Fetch-side lookup
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic             if_taken;

    assign if_idx   = bus.if_pc[IDX_W-1:0];
    assign if_tag   = bus.if_pc[29:IDX_W];
    assign if_hit   = bus.if_valid & valid_reg[if_idx] & (tag_mem[if_idx] == if_tag);
    assign if_taken = if_hit & ctr_mem[if_idx][1];

    assign bus.pred_taken = if_taken;
    assign bus.pred_npc   = if_taken ? tgt_mem[if_idx] : (bus.if_pc + 30'd1);

    // ------------------------------------------------------------------
    // Decode-side resolution
    // ------------------------------------------------------------------
    logic [29:0] seq;
    logic [29:0] br_tgt;
    logic [29:0] j_tgt;
    logic [29:0] jr_tgt;
    logic [29:0] actual;
    logic        redirect;
    logic        unused_reg_lsbs;

    assign seq    = bus.id_pc + 30'd1;
    assign br_tgt = seq + {{14{bus.offset[15]}}, bus.offset};
    assign j_tgt  = {seq[29:26], bus.instr_index};
    assign jr_tgt = bus.reg_index[31:2];
    // JR targets are word aligned; the byte-offset bits carry no information.
    assign unused_reg_lsbs = ^bus.reg_index[1:0];

    always_comb begin
        actual = seq;
        if (bus.go_exc) begin
            actual = EXC_HANDLER;
        end else if (bus.npc_from_epc) begin
            actual = bus.epc;
        end else if (bus.npc_from_gpr) begin
            actual = jr_tgt;
        end else if (bus.jmp) begin
            actual = j_tgt;
        end else if (bus.is_branch && bus.branch_avail) begin
            actual = br_tgt;
        end
    end

    // An exception always flushes, even if ID is empty or stalled.
    assign redirect = bus.go_exc |
                      (bus.id_valid & ~bus.id_stall & (actual != bus.id_pred_npc));

    assign bus.redirect       = redirect;
    assign bus.redirect_pc    = actual;
    assign bus.mispredict_cnt = cnt_reg;

    // ------------------------------------------------------------------
    // Training decision for the instruction leaving ID
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]   id_idx;
    logic [TAG_W-1:0]   id_tag;
    logic               id_hit;
    logic               train_ok;
    logic               wr_en;
    logic [29:0]        wr_tgt;
    logic [1:0]         wr_ctr;
    logic [ENTRIES-1:0] wr_sel;

    assign id_idx   = bus.id_pc[IDX_W-1:0];
    assign id_tag   = bus.id_pc[29:IDX_W];
    assign id_hit   = valid_reg[id_idx] & (tag_mem[id_idx] == id_tag);
    // ERET targets come from EPC and are not worth caching.
    assign train_ok = bus.id_valid & ~bus.id_stall & ~bus.go_exc & ~bus.npc_from_epc;

    always_comb begin
        wr_en  = 1'b0;
        wr_tgt = tgt_mem[id_idx];
        wr_ctr = ctr_mem[id_idx];
        if (train_ok) begin
            if (bus.npc_from_gpr || bus.jmp) begin
                // Unconditional jumps are installed strongly taken.
                wr_en  = 1'b1;
                wr_tgt = bus.npc_from_gpr ? jr_tgt : j_tgt;
                wr_ctr = 2'b11;
            end else if (bus.is_branch) begin
                if (bus.branch_avail) begin
                    wr_en  = 1'b1;
                    wr_tgt = br_tgt;
                    if (!id_hit) begin
                        wr_ctr = 2'b10;
                    end else if (ctr_mem[id_idx] != 2'b11) begin
                        wr_ctr = ctr_mem[id_idx] + 2'd1;
                    end
                end else if (id_hit) begin
                    // Keep the entry and its target; only weaken it.
                    wr_en = 1'b1;
                    if (ctr_mem[id_idx] != 2'b00) begin
                        wr_ctr = ctr_mem[id_idx] - 2'd1;
                    end
                end
            end
        end
    end

    // One-hot write select per BTB entry.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en & (id_idx == IDX_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_reg | wr_sel;
        end
    end

    // Payload writes are suppressed while reset is held so nothing pending
    // survives into the cleared table.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            tag_mem[id_idx] <= id_tag;
            tgt_mem[id_idx] <= wr_tgt;
            ctr_mem[id_idx] <= wr_ctr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (redirect && !bus.go_exc && !(&cnt_reg)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_npc_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_npc_predict_unit
//   Scoreboard bench. The stimulus process drives one slot per cycle, asks
//   the reference model for the expected outputs and queues them; the
//   monitor process pops and compares on the falling edge. The model keeps
//   the BTB as an associative array keyed by index holding the full PC of
//   the branch that owns the entry.
// ---------------------------------------------------------------------------
module tb_npc_predict_unit;
    localparam int          ENTRIES = 16;
    localparam int          CNT_W   = 4;
    localparam logic [29:0] EXC     = 30'h00001060;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    npc_predict_if #(.CNT_W(CNT_W)) bus ();

    npc_predict_unit #(
        .ENTRIES    (ENTRIES),
        .EXC_HANDLER(EXC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        bit        if_valid;
        bit [29:0] if_pc;
        bit        id_valid;
        bit        id_stall;
        bit [29:0] id_pc;
        bit [29:0] id_pred_npc;
        bit        is_branch;
        bit        branch_avail;
        bit [15:0] offset;
        bit        jmp;
        bit [25:0] instr_index;
        bit        gpr;
        bit [31:0] reg_index;
        bit        eret;
        bit [29:0] epc;
        bit        go_exc;
    } stim_t;

    typedef struct {
        bit [29:0]      pred_npc;
        bit             pred_taken;
        bit             redirect;
        bit [29:0]      redirect_pc;
        bit [CNT_W-1:0] cnt;
    } exp_t;

    typedef struct {
        bit [29:0] pc;
        bit [29:0] tgt;
        int        ctr;
    } ent_t;

    ent_t        btb[int];
    int unsigned model_cnt;
    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_txn = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_lookup(input bit [29:0] pc, output ent_t e);
        int idx;
        idx = int'(pc % ENTRIES);
        e   = '{pc: 30'd0, tgt: 30'd0, ctr: 0};
        if (!btb.exists(idx)) return 1'b0;
        e = btb[idx];
        return (e.pc / ENTRIES) == (pc / ENTRIES);
    endfunction

    function automatic bit [29:0] m_pred(input bit valid, input bit [29:0] pc, output bit taken);
        ent_t e;
        bit   hit;
        hit   = m_lookup(pc, e);
        taken = valid && hit && (e.ctr >= 2);
        return taken ? e.tgt : pc + 30'd1;
    endfunction

    function automatic bit [29:0] m_actual(input stim_t s);
        bit [29:0] seq;
        seq = s.id_pc + 30'd1;
        if (s.go_exc) return EXC;
        if (s.eret) return s.epc;
        if (s.gpr) return 30'(s.reg_index / 4);
        if (s.jmp) return (seq & 30'h3C00_0000) | 30'(s.instr_index);
        if (s.is_branch && s.branch_avail) return seq + 30'(int'($signed(s.offset)));
        return seq;
    endfunction

    task automatic m_train(input stim_t s, input bit redir);
        ent_t e;
        bit   hit;
        int   idx;
        if (redir && !s.go_exc && model_cnt < (1 << CNT_W) - 1) model_cnt++;
        if (!s.id_valid || s.id_stall || s.go_exc || s.eret) return;
        idx = int'(s.id_pc % ENTRIES);
        hit = m_lookup(s.id_pc, e);
        if (s.gpr || s.jmp) begin
            btb[idx] = '{pc: s.id_pc, tgt: m_actual(s), ctr: 3};
        end else if (s.is_branch) begin
            if (s.branch_avail) begin
                if (hit) btb[idx] = '{pc: s.id_pc, tgt: m_actual(s), ctr: (e.ctr == 3) ? 3 : e.ctr + 1};
                else     btb[idx] = '{pc: s.id_pc, tgt: m_actual(s), ctr: 2};
            end else if (hit) begin
                btb[idx].ctr = (e.ctr == 0) ? 0 : e.ctr - 1;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.if_valid     = s.if_valid;
        bus.if_pc        = s.if_pc;
        bus.id_valid     = s.id_valid;
        bus.id_stall     = s.id_stall;
        bus.id_pc        = s.id_pc;
        bus.id_pred_npc  = s.id_pred_npc;
        bus.is_branch    = s.is_branch;
        bus.branch_avail = s.branch_avail;
        bus.offset       = s.offset;
        bus.jmp          = s.jmp;
        bus.instr_index  = s.instr_index;
        bus.npc_from_gpr = s.gpr;
        bus.reg_index    = s.reg_index;
        bus.npc_from_epc = s.eret;
        bus.epc          = s.epc;
        bus.go_exc       = s.go_exc;
    endtask

    task automatic apply(input stim_t s, input bit do_rst);
        exp_t e;
        bit   tk;
        @(posedge clk);
        #1;
        drive(s);
        if (do_rst) begin
            reset     = 1'b1;
            btb.delete();
            model_cnt = 0;
        end else begin
            reset = 1'b0;
        end
        e.pred_npc    = m_pred(s.if_valid, s.if_pc, tk);
        e.pred_taken  = tk;
        e.redirect_pc = m_actual(s);
        e.redirect    = s.go_exc || (s.id_valid && !s.id_stall && e.redirect_pc != s.id_pred_npc);
        e.cnt         = CNT_W'(model_cnt);
        sb.push_back(e);
        if (!do_rst) m_train(s, e.redirect);
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        bit    tk;
        s = idle_stim();
        s.if_valid = ($urandom_range(0, 9) != 0);
        s.if_pc    = 30'h100 + 30'($urandom_range(0, 47));
        if ($urandom_range(0, 15) == 0) s.id_pc = 30'h3FFF_FFF0 + 30'($urandom_range(0, 15));
        else                            s.id_pc = 30'h100 + 30'($urandom_range(0, 47));
        if ($urandom_range(0, 1) == 0) s.if_pc = s.id_pc;
        s.id_valid     = ($urandom_range(0, 9) != 0);
        s.id_stall     = ($urandom_range(0, 9) == 0);
        s.is_branch    = ($urandom_range(0, 99) < 45);
        s.branch_avail = $urandom_range(0, 1);
        s.offset       = 16'($urandom_range(0, 15)) - 16'd8;
        if ($urandom_range(0, 7) == 0) s.offset = 16'($urandom());
        s.jmp          = ($urandom_range(0, 99) < 15);
        s.instr_index  = 26'h100 + 26'($urandom_range(0, 63));
        s.gpr          = ($urandom_range(0, 99) < 10);
        s.reg_index    = 32'h400 + 32'($urandom_range(0, 255));
        s.eret         = ($urandom_range(0, 99) < 5);
        s.epc          = 30'($urandom());
        s.go_exc       = ($urandom_range(0, 99) < 4);
        case ($urandom_range(0, 4))
            0:       s.id_pred_npc = s.id_pc + 30'd1;
            1:       s.id_pred_npc = 30'($urandom());
            default: s.id_pred_npc = m_pred(1'b1, s.id_pc, tk);
        endcase
        return s;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_txn++;
                $display("txn %0d: if_pc=%h pred_npc=%h taken=%0b redirect=%0b rpc=%h cnt=%0d",
                         n_txn, bus.if_pc, bus.pred_npc, bus.pred_taken, bus.redirect,
                         bus.redirect_pc, bus.mispredict_cnt);
                chk("pred_npc", 32'(bus.pred_npc), 32'(e.pred_npc));
                chk("pred_taken", 32'(bus.pred_taken), 32'(e.pred_taken));
                chk("redirect", 32'(bus.redirect), 32'(e.redirect));
                if (e.redirect) chk("redirect_pc", 32'(bus.redirect_pc), 32'(e.redirect_pc));
                chk("mispredict_cnt", 32'(bus.mispredict_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        stim_t s;
        model_cnt = 0;
        reset     = 1'b1;
        drive(idle_stim());
        repeat (3) @(posedge clk);

        // 1: empty table falls through
        s = idle_stim(); s.if_valid = 1; s.if_pc = 30'h100;
        apply(s, 0);
        @(negedge clk);
        chk("t1_pred_npc", 32'(bus.pred_npc), 32'h101);
        chk("t1_cnt", 32'(bus.mispredict_cnt), 32'h0);

        // 2: taken backward branch allocates and redirects
        s.id_valid = 1; s.id_pc = 30'h100; s.id_pred_npc = 30'h101;
        s.is_branch = 1; s.branch_avail = 1; s.offset = 16'hFFFC;
        apply(s, 0);
        @(negedge clk);
        chk("t2_redirect_pc", 32'(bus.redirect_pc), 32'hFD);
        s = idle_stim(); s.if_valid = 1; s.if_pc = 30'h100;
        apply(s, 0);
        @(negedge clk);
        chk("t2_pred_npc", 32'(bus.pred_npc), 32'hFD);
        chk("t2_cnt", 32'(bus.mispredict_cnt), 32'h1);

        // 3: two not-taken resolutions walk the counter 2->1->0
        s = idle_stim(); s.if_valid = 1; s.if_pc = 30'h100;
        s.id_valid = 1; s.id_pc = 30'h100; s.id_pred_npc = 30'hFD;
        s.is_branch = 1; s.branch_avail = 0; s.offset = 16'hFFFC;
        apply(s, 0);
        apply(s, 0);
        @(negedge clk);
        chk("t3_taken", 32'(bus.pred_taken), 32'h0);
        chk("t3_redirect_pc", 32'(bus.redirect_pc), 32'h101);

        // 4: exception while stalled, with a jump also present
        s = idle_stim(); s.id_valid = 1; s.id_stall = 1; s.id_pc = 30'h300;
        s.jmp = 1; s.instr_index = 26'h55; s.go_exc = 1;
        apply(s, 0);
        @(negedge clk);
        chk("t4_redirect", 32'(bus.redirect), 32'h1);
        chk("t4_redirect_pc", 32'(bus.redirect_pc), 32'h1060);
        s = idle_stim(); s.if_valid = 1; s.if_pc = 30'h300;
        apply(s, 0);
        @(negedge clk);
        chk("t4_cnt", 32'(bus.mispredict_cnt), 32'h3);

        // 5: JR then J sharing index 0
        s = idle_stim(); s.id_valid = 1; s.id_pc = 30'h200; s.id_pred_npc = 30'h201;
        s.gpr = 1; s.reg_index = 32'h0000_3003;
        apply(s, 0);
        @(negedge clk);
        chk("t5_jr_pc", 32'(bus.redirect_pc), 32'hC00);
        s = idle_stim(); s.id_valid = 1; s.id_pc = 30'h210; s.id_pred_npc = 30'h211;
        s.jmp = 1; s.instr_index = 26'hC00;
        apply(s, 0);
        s = idle_stim(); s.if_valid = 1; s.if_pc = 30'h210;
        apply(s, 0);
        @(negedge clk);
        chk("t5_j_pred", 32'(bus.pred_npc), 32'hC00);
        s.if_pc = 30'h200;
        apply(s, 0);

        // 6: fall-through wraps at the top of the address space
        s = idle_stim(); s.id_valid = 1; s.id_pc = 30'h3FFF_FFFF; s.id_pred_npc = 30'h0;
        apply(s, 0);
        @(negedge clk);
        chk("t6_redirect", 32'(bus.redirect), 32'h0);

        // Randomized traffic with a reset in the middle
        for (int i = 0; i < 600; i++) begin
            apply(rand_stim(), (i == 300) || (i == 301));
        end

        // Table must be empty right after a reset
        apply(idle_stim(), 1);
        s = idle_stim(); s.if_valid = 1; s.if_pc = 30'h210;
        apply(s, 0);

        apply(idle_stim(), 0);
        @(negedge clk);
        @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
